intr_msi_sched: RTL and testbench
=================================

# intr_msi_sched

Multi-source interrupt scheduler for the QEMU PCIe bridge. It collects up to NSRC user-logic interrupt events, latches each one as pending, and picks one per round using round-robin arbitration. It then drives the single intx_msi_request / intx_msi_grant handshake that the bridge's interrupt port forwards to the host. It sits between user interrupt sources and the bridge interrupt port, and presents the selected source index as the MSI vector.

## Interface

Parameters:
- NSRC, 8, number of interrupt sources (2..32)
- VECW, 5, MSI vector width; must satisfy 2^VECW >= NSRC
- HOLDOFF, 4, idle cycles enforced after each completed or abandoned request (>=1)
- TOW, 16, width of grant-timeout counter (used only with INTR_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_src_irq  in  NSRC  per-source interrupt line; a rising edge is an event
- i_src_mask  in  NSRC  1 = source excluded from arbitration (pending still latched)
- o_intx_msi_request  out  1  request to the bridge interrupt port
- i_intx_msi_grant  in  1  bridge acknowledge; sampled only while the request is high
- o_msi_vector  out  VECW  index of the selected source, zero-extended
- o_pending  out  NSRC  pending register
- o_busy  out  1  high when the FSM is not in IDLE
- o_timeout_err  out  1  one-cycle pulse when a request is abandoned

## Operation

- Edge detect: the prior value of each i_src_irq is registered (prev). A bit with i_src_irq=1 and prev=0 sets pending[i].
- Pending bits stay set until their source is granted. A set and a clear of the same bit in the same cycle leaves the bit set; the event is not lost.
- Eligible set = pending & ~i_src_mask.
- Round-robin: the search starts at last+1 and wraps modulo NSRC. The first eligible index wins. last resets to NSRC-1, so index 0 has first priority after reset.
- FSM states are IDLE, REQ and HOLD.
  - IDLE: if the eligible set is non-empty, register sel and o_msi_vector = sel, then go to REQ. Otherwise stay in IDLE.
  - REQ: o_intx_msi_request=1, and o_msi_vector stays stable. When the grant is sampled high: clear pending[sel], set last=sel, and go to HOLD.
  - HOLD: count HOLDOFF cycles, then go to IDLE.
- Mask or pending changes during REQ or HOLD do not withdraw or alter the current request.
- A grant received outside REQ is ignored.
- Reset mid-operation: the request drops on the next edge, all pending bits clear, and FSM=IDLE. The handshake is abandoned with no error pulse.
- prev resets to 0, so a source held high through reset registers exactly one event after reset.

## Timing

- Reset values:
  - o_intx_msi_request=0, o_msi_vector=0, o_pending=0, o_busy=0, o_timeout_err=0
  - FSM=IDLE, last=NSRC-1, prev=0, counters=0
- Event latency: a rising edge sampled at edge t gives pending visible at t+1. Request high and the vector valid at t+2 if the FSM is IDLE.
- Grant sampled at edge g gives request low and pending[sel] clear at g+1. HOLD spans g+1..g+HOLDOFF, IDLE is at g+HOLDOFF+1, and the earliest next request is at g+HOLDOFF+2.
- A grant on the same edge that the request first rises is valid; minimum REQ duration is 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- INTR_TIMEOUT_EN defined:
  - A TOW-bit counter clears on REQ entry and increments every REQ cycle.
  - If it reaches 2^TOW-1 with no grant, the request drops and o_timeout_err pulses for 1 cycle.
  - pending[sel] is kept, last=sel so the next round moves on to another source, and the FSM goes to HOLD.
  - A grant on the terminal-count cycle wins over the timeout.
- INTR_TIMEOUT_EN undefined: REQ waits indefinitely, o_timeout_err is tied 0, and no counter is instantiated.

## Test plan

- Single event: pulse src 3 at t, grant one cycle after the request rises. Required: request high at t+2, vector=3, pending=0x00 after the grant, o_busy low at g+5 (HOLDOFF=4).
- Round-robin: src 0, 2 and 5 rise on the same edge with immediate grants. Required: vectors 0, 2, 5 in order, with successive requests 6 cycles apart.
- Masking: src 1 masked, src 4 unmasked, both rise. Required: only vector 4 is requested and pending keeps bit 1. Unmasking then yields vector 1.
- Re-event during service: src 2 rises again on the same edge as its grant. Required: pending[2] stays 1 and vector 2 is requested again after HOLD.
- Reset mid-request: assert i_rst while the request is high. Required: request low, pending=0, FSM IDLE on the next edge; with src 6 held high, one request with vector 6 follows after reset.
- INTR_TIMEOUT_EN, TOW=4, never grant src 7 with src 1 also pending. Required: request drops after 15 REQ cycles and o_timeout_err pulses once. The next request is vector 1, and pending[7] stays set.

Source files
------------

// File: rtl/intr_msi_sched.sv
// intr_msi_sched
// Multi-source interrupt scheduler. Rising edges on i_src_irq are latched as
// pending. Unmasked pending sources are served one at a time in round-robin
// order over a single request/grant handshake, and the winning source index
// is presented as the MSI vector.
// Optional feature macro: INTR_TIMEOUT_EN. When it is defined, a request that
// goes ungranted for 2^TOW-1 cycles is abandoned and o_timeout_err pulses.
// When it is undefined, a request waits for its grant indefinitely.
module intr_msi_sched #(
    parameter int NSRC    = 8,
    parameter int VECW    = 5,
    parameter int HOLDOFF = 4,
    parameter int TOW     = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NSRC-1:0] i_src_irq,
    input  logic [NSRC-1:0] i_src_mask,
    output logic            o_intx_msi_request,
    input  logic            i_intx_msi_grant,
    output logic [VECW-1:0] o_msi_vector,
    output logic [NSRC-1:0] o_pending,
    output logic            o_busy,
    output logic            o_timeout_err
);

    localparam int IDXW = $clog2(NSRC);
    localparam int HCW  = $clog2(HOLDOFF + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Reject configurations the vector or the counters cannot represent.
    if (NSRC < 2 || NSRC > 32 || (2 ** VECW) < NSRC || HOLDOFF < 1 || TOW < 1) begin : g_bad_cfg
        $error("intr_msi_sched: invalid parameter set");
    end

    logic [1:0]      r_state;
    logic            r_req;
    logic            r_busy;
    logic [NSRC-1:0] r_prev;
    logic [NSRC-1:0] r_pending;
    logic [IDXW-1:0] r_last;
    logic [IDXW-1:0] r_sel;
    logic [VECW-1:0] r_vec;
    logic [HCW-1:0]  r_hold_cnt;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_clr;
    logic            w_grant_hit;
    logic            w_has_hi;
    logic [IDXW-1:0] w_pick_hi;
    logic [IDXW-1:0] w_pick_lo;
    logic [IDXW-1:0] w_pick;

    assign w_rise      = i_src_irq & ~r_prev;
    assign w_grant_hit = (r_state == S_REQ) && i_intx_msi_grant;

    // Round-robin pick: the lowest eligible index above r_last wins, otherwise
    // the search wraps to the lowest eligible index overall.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
        w_eligible = r_pending & ~i_src_mask;
        w_has_hi   = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_pick_lo = IDXW'(i);
                if (i > int'(r_last)) begin
                    w_pick_hi = IDXW'(i);
                    w_has_hi  = 1'b1;
                end
            end
        end
        w_pick = w_has_hi ? w_pick_hi : w_pick_lo;
    end

    // Clear mask: only the source being granted this cycle loses its pending bit.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_clr[i] = w_grant_hit && (r_sel == IDXW'(i));
        end
    end

    // Edge detect and pending latch; a new event outranks a same-cycle clear.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_src_irq;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

`ifdef INTR_TIMEOUT_EN
    logic [TOW-1:0] r_tcnt;
    logic           r_terr;
`endif

    // Handshake FSM: IDLE picks a source, REQ holds the request until it is
    // granted (or abandoned), and HOLD enforces the idle gap before the next round.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_last     <= IDXW'(NSRC - 1);
            r_sel      <= '0;
            r_vec      <= '0;
            r_hold_cnt <= '0;
`ifdef INTR_TIMEOUT_EN
            r_tcnt     <= '0;
            r_terr     <= 1'b0;
`endif
        end else begin
`ifdef INTR_TIMEOUT_EN
            r_terr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (|w_eligible) begin
                        r_sel   <= w_pick;
                        r_vec   <= VECW'(w_pick);
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
`ifdef INTR_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (i_intx_msi_grant) begin
                        r_last     <= r_sel;
                        r_req      <= 1'b0;
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end
`ifdef INTR_TIMEOUT_EN
                    // The count reaches 2^TOW-1 on this edge: give up, but keep
                    // the source pending and move the round-robin pointer past it.
                    else if (r_tcnt == ~TOW'(1)) begin
                        r_tcnt     <= r_tcnt + 1'b1;
                        r_last     <= r_sel;
                        r_req      <= 1'b0;
                        r_terr     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (r_hold_cnt == HCW'(HOLDOFF - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_intx_msi_request = r_req;
    assign o_msi_vector       = r_vec;
    assign o_pending          = r_pending;
    assign o_busy             = r_busy;
`ifdef INTR_TIMEOUT_EN
    assign o_timeout_err      = r_terr;
`else
    assign o_timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_intr_msi_sched.sv
// tb_intr_msi_sched
// Directed scenarios followed by a randomized phase, all compared every cycle
// against a transaction-level reference model of the scheduler. Define
// INTR_TIMEOUT_EN for both files to include the abandoned-request scenario.
module tb_intr_msi_sched;

    localparam int NSRC    = 8;
    localparam int VECW    = 5;
    localparam int HOLDOFF = 4;
    localparam int TOW     = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src_irq;
    logic [NSRC-1:0] src_mask;
    logic            grant;
    logic            req;
    logic [VECW-1:0] vec;
    logic [NSRC-1:0] pend;
    logic            busy;
    logic            terr;

    always #5 clk = ~clk;

    intr_msi_sched #(
        .NSRC(NSRC), .VECW(VECW), .HOLDOFF(HOLDOFF), .TOW(TOW)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_src_irq          (src_irq),
        .i_src_mask         (src_mask),
        .o_intx_msi_request (req),
        .i_intx_msi_grant   (grant),
        .o_msi_vector       (vec),
        .o_pending          (pend),
        .o_busy             (busy),
        .o_timeout_err      (terr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending set, pointer to last served source, whether a
    // request is outstanding, and the cycle from which a new round may start.
    logic [NSRC-1:0] m_pend = '0;
    logic [NSRC-1:0] m_prev = '0;
    logic [VECW-1:0] m_vec  = '0;
    logic            m_req  = 1'b0;
    logic            m_terr = 1'b0;
    int              m_last = NSRC - 1;
    int              m_free = 0;
    int              m_cyc  = 0;
    int              m_tcnt = 0;

    always @(posedge clk) begin : ref_model
        logic [NSRC-1:0] evt;
        int win;
        m_terr = 1'b0;
        if (rst) begin
            m_pend = '0;
            m_prev = '0;
            m_vec  = '0;
            m_req  = 1'b0;
            m_last = NSRC - 1;
            m_free = 0;
            m_tcnt = 0;
        end else begin
            evt = src_irq & ~m_prev;
            if (m_req) begin
                if (grant) begin
                    m_pend[m_vec] = 1'b0;
                    m_last = int'(m_vec);
                    m_req  = 1'b0;
                    m_free = m_cyc + HOLDOFF + 1;
                end
`ifdef INTR_TIMEOUT_EN
                else begin
                    m_tcnt++;
                    if (m_tcnt == (1 << TOW) - 1) begin
                        m_last = int'(m_vec);
                        m_req  = 1'b0;
                        m_terr = 1'b1;
                        m_free = m_cyc + HOLDOFF + 1;
                    end
                end
`endif
            end else if (m_cyc >= m_free) begin
                win = -1;
                for (int k = 0; k < NSRC; k++) begin
                    if (win < 0 && m_pend[(m_last + 1 + k) % NSRC] && !src_mask[(m_last + 1 + k) % NSRC])
                        win = (m_last + 1 + k) % NSRC;
                end
                if (win >= 0) begin
                    m_req  = 1'b1;
                    m_vec  = VECW'(win);
                    m_tcnt = 0;
                end
            end
            m_pend = m_pend | evt;
            m_prev = src_irq;
        end
        m_cyc++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_busy;
        exp_busy = m_req || (m_cyc < m_free);
        checks++;
        assert (req === m_req) else begin
            errors++; $error("FAIL %s request observed %b expected %b", tag, req, m_req);
        end
        checks++;
        assert (vec === m_vec) else begin
            errors++; $error("FAIL %s vector observed %0d expected %0d", tag, vec, m_vec);
        end
        checks++;
        assert (pend === m_pend) else begin
            errors++; $error("FAIL %s pending observed %h expected %h", tag, pend, m_pend);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++; $error("FAIL %s busy observed %b expected %b", tag, busy, exp_busy);
        end
        checks++;
        assert (terr === m_terr) else begin
            errors++; $error("FAIL %s timeout_err observed %b expected %b", tag, terr, m_terr);
        end
    endtask

    // One clock: inputs were set after a falling edge, outputs are compared at the next falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic wait_req(input string tag, input int budget, output int waited);
        waited = 0;
        while (req !== 1'b1 && waited < budget) begin
            step(tag);
            waited++;
        end
        check_val({tag, "_arrived"}, {31'd0, req}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; src_irq = '0; src_mask = '0; grant = 1'b0;
        step("rst");
        step("rst");
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int waited;
        int n;
        int tpulses;
        logic [VECW-1:0] vecs [3];
        int times [3];
        int t_now;

        // Reset values.
        do_reset();
        check_val("rst_req",     {31'd0, req},  32'd0);
        check_val("rst_vec",     32'(vec),      32'd0);
        check_val("rst_pending", 32'(pend),     32'd0);
        check_val("rst_busy",    {31'd0, busy}, 32'd0);
        check_val("rst_terr",    {31'd0, terr}, 32'd0);

        // Single event on source 3: request and vector at t+2, grant a cycle later.
        src_irq = 8'h08; step("se_edge");
        src_irq = '0;    step("se_lat");
        check_val("se_req_t2", {31'd0, req}, 32'd1);
        check_val("se_vec",    32'(vec),     32'd3);
        step("se_wait");
        grant = 1'b1; step("se_grant"); grant = 1'b0;
        check_val("se_pend_clr", 32'(pend),     32'd0);
        check_val("se_req_low",  {31'd0, req},  32'd0);
        repeat (3) step("se_hold");
        check_val("se_busy_hold", {31'd0, busy}, 32'd1);
        step("se_idle");
        check_val("se_busy_g5",   {31'd0, busy}, 32'd0);

        // Round-robin: sources 0, 2, 5 together, grant held high.
        do_reset();
        src_irq = 8'b0010_0101; step("rr_edge");
        src_irq = '0; grant = 1'b1;
        n = 0; t_now = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            step("rr");
            t_now++;
            if (req === 1'b1) begin
                vecs[n] = vec; times[n] = t_now; n++;
            end
        end
        grant = 1'b0;
        check_val("rr_count", 32'(n), 32'd3);
        if (n == 3) begin
            check_val("rr_vec0", 32'(vecs[0]), 32'd0);
            check_val("rr_vec1", 32'(vecs[1]), 32'd2);
            check_val("rr_vec2", 32'(vecs[2]), 32'd5);
            check_val("rr_gap01", 32'(times[1] - times[0]), 32'(HOLDOFF + 2));
            check_val("rr_gap12", 32'(times[2] - times[1]), 32'(HOLDOFF + 2));
        end

        // Masking: source 1 masked, source 4 open; only 4 is served until unmasked.
        do_reset();
        src_mask = 8'h02; src_irq = 8'h12; step("mk_edge");
        src_irq = '0; grant = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step("mk");
            if (req === 1'b1) begin
                n++;
                check_val("mk_vec", 32'(vec), 32'd4);
            end
        end
        check_val("mk_count", 32'(n), 32'd1);
        check_val("mk_pend1", {31'd0, pend[1]}, 32'd1);
        src_mask = '0;
        wait_req("mk_unmask", 10, waited);
        check_val("mk_vec_unmask", 32'(vec), 32'd1);
        step("mk_grant");
        grant = 1'b0;

        // Re-event on the grant edge keeps the source pending for another round.
        do_reset();
        src_irq = 8'h04; step("re_edge");
        src_irq = '0;
        wait_req("re_req", 10, waited);
        check_val("re_vec", 32'(vec), 32'd2);
        grant = 1'b1; src_irq = 8'h04; step("re_grant");
        grant = 1'b0; src_irq = '0;
        check_val("re_pend2",   {31'd0, pend[2]}, 32'd1);
        check_val("re_req_low", {31'd0, req},     32'd0);
        wait_req("re_again", 12, waited);
        check_val("re_gap", 32'(waited), 32'(HOLDOFF + 1));
        check_val("re_vec_again", 32'(vec), 32'd2);
        grant = 1'b1; step("re_grant2"); grant = 1'b0;

        // Reset during a request; source 6 held high through reset fires exactly once.
        do_reset();
        src_irq = 8'h40;
        wait_req("rm_req", 10, waited);
        rst = 1'b1; step("rm_rst");
        check_val("rm_req_low", {31'd0, req},  32'd0);
        check_val("rm_pending", 32'(pend),     32'd0);
        check_val("rm_busy",    {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_req("rm_after", 10, waited);
        check_val("rm_vec", 32'(vec), 32'd6);
        grant = 1'b1; step("rm_grant"); grant = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step("rm_quiet");
            if (req === 1'b1) n++;
        end
        check_val("rm_single", 32'(n), 32'd0);
        src_irq = '0;

`ifdef INTR_TIMEOUT_EN
        // Source 7 is never granted while source 1 waits behind it.
        do_reset();
        src_irq = 8'h40; step("to_seed");
        src_irq = '0;
        wait_req("to_seed_req", 10, waited);
        grant = 1'b1; step("to_seed_grant"); grant = 1'b0;
        src_irq = 8'h82; step("to_edge");
        src_irq = '0;
        wait_req("to_req", 10, waited);
        check_val("to_vec7", 32'(vec), 32'd7);
        n = 1; tpulses = 0;
        for (int i = 0; i < 40 && req === 1'b1; i++) begin
            step("to_hold");
            if (req === 1'b1) n++;
            if (terr === 1'b1) tpulses++;
        end
        check_val("to_req_cycles", 32'(n), 32'((1 << TOW) - 1));
        repeat (3) begin
            step("to_after");
            if (terr === 1'b1) tpulses++;
        end
        check_val("to_pulses", 32'(tpulses), 32'd1);
        check_val("to_pend7", {31'd0, pend[7]}, 32'd1);
        wait_req("to_next", 10, waited);
        check_val("to_vec1", 32'(vec), 32'd1);
        grant = 1'b1; step("to_grant1"); grant = 1'b0;
`endif

        // Randomized phase: sparse edges, random masks and grants, rare resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            src_irq  = src_irq ^ NSRC'($urandom & $urandom & $urandom);
            src_mask = NSRC'($urandom & $urandom);
            grant    = 1'($urandom_range(1));
            rst      = ($urandom_range(199) == 0);
            step("rand");
        end
        rst = 1'b0; grant = 1'b0;
        step("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
